// File: rtl/fb_pkg.sv
// Shared definitions for the framebuffer loader: sizes, ACK byte, FSM encoding
// and the lane-select to nibble-position mapping.
package fb_pkg;

    localparam int ROWS_DEFAULT = 80;
    localparam int MAX_ROWS     = 128;

    localparam logic [7:0] ACK_BYTE = 8'h06;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FILL = 2'd1,
        ST_ACK  = 2'd2
    } fb_state_e;

    // Low bit of the plane-0 nibble for each lane; plane 1 sits PLANE1_OFS higher.
    localparam logic [4:0] LANE0_POS  = 5'd12;
    localparam logic [4:0] LANE1_POS  = 5'd8;
    localparam logic [4:0] LANE2_POS  = 5'd4;
    localparam logic [4:0] LANE3_POS  = 5'd0;
    localparam logic [4:0] PLANE1_OFS = 5'd16;

    function automatic logic [4:0] lane_pos(input logic [1:0] lane);
        logic [4:0] pos;
        case (lane)
            2'd0:    pos = LANE0_POS;
            2'd1:    pos = LANE1_POS;
            2'd2:    pos = LANE2_POS;
            default: pos = LANE3_POS;
        endcase
        return pos;
    endfunction

    // Even byte bits feed plane 0, odd byte bits feed plane 1.
    function automatic logic [3:0] plane_bits(input logic [7:0] b, input logic plane);
        return plane ? {b[7], b[5], b[3], b[1]} : {b[6], b[4], b[2], b[0]};
    endfunction

endpackage

// File: rtl/fb_loader_if.sv
// Bundle of the UART-side byte stream and display-side row read port of fb_loader.
interface fb_loader_if;
    logic [7:0]  rx_data;
    logic        rx_strobe;
    logic [7:0]  row;
    logic [31:0] pixels;
    logic [7:0]  tx_data;
    logic        tx_strobe;
    logic        frame_done;
    logic        led;

    modport master (
        output rx_data, rx_strobe, row,
        input  pixels, tx_data, tx_strobe, frame_done, led
    );

    modport slave (
        input  rx_data, rx_strobe, row,
        output pixels, tx_data, tx_strobe, frame_done, led
    );
endinterface

// File: rtl/fb_ram.sv
// ROWS x 32 frame store: bit-masked write port, registered read port that
// returns 0 for out-of-range rows and old data on a same-row collision.
module fb_ram
    import fb_pkg::*;
#(
    parameter int ROWS = ROWS_DEFAULT,
    parameter int AW   = (ROWS > 1) ? $clog2(ROWS) : 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [31:0]   wdata,
    input  logic [31:0]   wmask,
    input  logic [7:0]    raddr,
    output logic [31:0]   rdata
);

    localparam logic [8:0] ROWS_LIM = 9'(ROWS);

    logic [31:0] mem [ROWS];

    // NOTE: the array has no reset branch; clearing it would turn the store into
    // flops and frame contents must survive reset anyway.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= (mem[waddr] & ~wmask) | (wdata & wmask);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rdata <= '0;
        end else if ({1'b0, raddr} < ROWS_LIM) begin
            rdata <= mem[raddr[AW-1:0]];
        end else begin
            rdata <= '0;
        end
    end

endmodule

// File: rtl/fb_loader.sv
// Streams UART bytes into a two-plane framebuffer, acks each complete frame.
// Optional idle-resync feature: define FB_LOADER_TIMEOUT_EN.
module fb_loader
    import fb_pkg::*;
#(
    parameter int ROWS    = ROWS_DEFAULT,
    parameter int TIMEOUT = 240000
) (
    input  logic        clk,
    input  logic        reset,
    fb_loader_if.slave  bus
);

    localparam int         AW       = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam logic [8:0] LAST_OFS = 9'(4 * ROWS - 1);

    if (ROWS < 1 || ROWS > MAX_ROWS || TIMEOUT < 1) begin : g_bad_params
        $error("fb_loader: ROWS must be 1..128 and TIMEOUT at least 1");
    end

    fb_state_e   state, state_nxt;
    logic [8:0]  offset, offset_nxt;
    logic        led_q;
    logic        timeout_hit;
    logic        we;
    logic [6:0]  wrow;
    logic [4:0]  pos;
    logic [31:0] wdata, wmask;
    logic [31:0] pix;

`ifdef FB_LOADER_TIMEOUT_EN
    localparam int            TW          = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TIMEOUT_CNT = TW'(TIMEOUT);

    logic [TW-1:0] idle_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            idle_cnt <= '0;
        end else if (bus.rx_strobe) begin
            idle_cnt <= '0;
        end else if (idle_cnt != TIMEOUT_CNT) begin
            idle_cnt <= idle_cnt + TW'(1);
        end
    end

    assign timeout_hit = (state == ST_FILL) && !bus.rx_strobe && (idle_cnt == TIMEOUT_CNT);
`else
    assign timeout_hit = 1'b0;
`endif

    // Bytes arriving while reset is held must not reach the store.
    assign we   = bus.rx_strobe && !reset;
    assign wrow = offset[8:2];
    assign pos  = lane_pos(offset[1:0]);

    always_comb begin
        wdata = ({28'd0, plane_bits(bus.rx_data, 1'b1)} << (pos + PLANE1_OFS))
              | ({28'd0, plane_bits(bus.rx_data, 1'b0)} << pos);
        wmask = (32'h0000_000F << (pos + PLANE1_OFS)) | (32'h0000_000F << pos);
    end

    fb_ram #(.ROWS(ROWS), .AW(AW)) u_ram (
        .clk   (clk),
        .reset (reset),
        .we    (we),
        .waddr (wrow[AW-1:0]),
        .wdata (wdata),
        .wmask (wmask),
        .raddr (bus.row),
        .rdata (pix)
    );

    // NOTE: every output of this block gets a default first, so no path leaves
    // a signal unassigned and no latch is inferred.
    always_comb begin
        state_nxt      = state;
        offset_nxt     = offset;
        bus.tx_strobe  = 1'b0;
        bus.frame_done = 1'b0;
        bus.tx_data    = '0;

        case (state)
            ST_IDLE: if (bus.rx_strobe) state_nxt = ST_FILL;
            ST_FILL: if (timeout_hit)   state_nxt = ST_IDLE;
            ST_ACK: begin
                bus.tx_strobe  = 1'b1;
                bus.frame_done = 1'b1;
                bus.tx_data    = ACK_BYTE;
                state_nxt      = bus.rx_strobe ? ST_FILL : ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase

        // A byte during ACK is offset 0 of the next frame, handled like any other.
        if (bus.rx_strobe) begin
            if (offset == LAST_OFS) begin
                offset_nxt = '0;
                state_nxt  = ST_ACK;
            end else begin
                offset_nxt = offset + 9'd1;
            end
        end else if (timeout_hit) begin
            offset_nxt = '0;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of process ordering.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= ST_IDLE;
            offset <= '0;
            led_q  <= 1'b0;
        end else begin
            state  <= state_nxt;
            offset <= offset_nxt;
            if (bus.rx_strobe) led_q <= ~led_q;
        end
    end

    assign bus.led    = led_q;
    assign bus.pixels = pix;

endmodule

// File: tb/tb_fb_loader.sv
// Directed bench for fb_loader (ROWS=80); exercises the idle resync when
// FB_LOADER_TIMEOUT_EN is defined, otherwise checks the offset is unaffected by idling.
module tb_fb_loader;

`ifdef FB_LOADER_TIMEOUT_EN
    localparam int TIMEOUT = 16;
`else
    localparam int TIMEOUT = 240000;
`endif

    logic clk = 1'b0;
    logic reset;

    fb_loader_if bus();

    fb_loader #(.ROWS(80), .TIMEOUT(TIMEOUT)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    int         fd_cnt  = 0;
    int         tx_cnt  = 0;
    int         led_tog = 0;
    logic [7:0] last_tx = 8'h00;
    logic       led_prev = 1'b0;

    always @(negedge clk) begin
        if (bus.frame_done === 1'b1) fd_cnt++;
        if (bus.tx_strobe === 1'b1) begin
            tx_cnt++;
            last_tx = bus.tx_data;
        end
        if (bus.led !== led_prev) led_tog++;
        led_prev = bus.led;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Called at a negedge; byte is captured at the following posedge.
    task automatic send(input logic [7:0] b);
        bus.rx_data   = b;
        bus.rx_strobe = 1'b1;
        @(negedge clk);
        bus.rx_strobe = 1'b0;
        @(negedge clk);
    endtask

    task automatic read_row(input logic [7:0] r, output logic [31:0] v);
        bus.row = r;
        @(negedge clk);
        v = bus.pixels;
    endtask

    typedef struct {
        logic [7:0]  data;
        logic [7:0]  row;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[12];

    initial begin
        logic [31:0] v;
        int base_fd, base_tx, base_led;

        // Rows 0..2 start at all-ones; each entry is the row after that byte.
        vecs[0]  = '{8'h01, 8'd0, 32'h0FFF_1FFF};
        vecs[1]  = '{8'h02, 8'd0, 32'h01FF_10FF};
        vecs[2]  = '{8'hAA, 8'd0, 32'h01FF_100F};
        vecs[3]  = '{8'h55, 8'd0, 32'h01F0_100F};
        vecs[4]  = '{8'h01, 8'd1, 32'h0FFF_1FFF};
        vecs[5]  = '{8'h02, 8'd1, 32'h01FF_10FF};
        vecs[6]  = '{8'h00, 8'd1, 32'h010F_100F};
        vecs[7]  = '{8'h00, 8'd1, 32'h0100_1000};
        vecs[8]  = '{8'hC3, 8'd2, 32'h9FFF_9FFF};
        vecs[9]  = '{8'h00, 8'd2, 32'h90FF_90FF};
        vecs[10] = '{8'hFF, 8'd2, 32'h90FF_90FF};
        vecs[11] = '{8'h0F, 8'd2, 32'h90F3_90F3};

        bus.rx_data   = 8'h00;
        bus.rx_strobe = 1'b0;
        bus.row       = 8'd0;
        reset         = 1'b1;
        repeat (3) @(negedge clk);

        check("rst_pixels",     bus.pixels,            32'h0);
        check("rst_tx_strobe",  32'(bus.tx_strobe),    32'h0);
        check("rst_frame_done", 32'(bus.frame_done),   32'h0);
        check("rst_tx_data",    32'(bus.tx_data),      32'h0);
        check("rst_led",        32'(bus.led),          32'h0);

        reset = 1'b0;
        @(negedge clk);
        base_fd = fd_cnt; base_tx = tx_cnt; base_led = led_tog;

        // Full frame of 0xFF.
        for (int i = 0; i < 320; i++) send(8'hFF);
        @(negedge clk);
        check("f1_frame_done_cnt", 32'(fd_cnt - base_fd),   32'd1);
        check("f1_tx_cnt",         32'(tx_cnt - base_tx),   32'd1);
        check("f1_tx_data",        32'(last_tx),            32'h06);
        check("f1_led_toggles",    32'(led_tog - base_led), 32'd320);
        for (int r = 0; r < 80; r++) begin
            read_row(8'(r), v);
            check($sformatf("f1_row%0d", r), v, 32'hFFFF_FFFF);
        end

        // Lane / bit mapping table, starting at offset 0.
        for (int i = 0; i < 12; i++) begin
            send(vecs[i].data);
            read_row(vecs[i].row, v);
            check($sformatf("map_vec%0d", i), v, vecs[i].exp);
        end

        // Read and write of row 3 in the same cycle returns the old word.
        bus.row       = 8'd3;
        bus.rx_data   = 8'h00;
        bus.rx_strobe = 1'b1;
        @(negedge clk);
        bus.rx_strobe = 1'b0;
        check("rdw_old", bus.pixels, 32'hFFFF_FFFF);
        @(negedge clk);
        check("rdw_new", bus.pixels, 32'h0FFF_0FFF);

        // Bring the frame to 100 bytes, then reset with a strobe held high.
        for (int i = 13; i < 100; i++) send(8'h00);
        bus.row       = 8'd0;
        bus.rx_data   = 8'hFF;
        bus.rx_strobe = 1'b1;
        reset         = 1'b1;
        @(negedge clk);
        check("midrst_pixels", bus.pixels,          32'h0);
        check("midrst_led",    32'(bus.led),        32'h0);
        @(negedge clk);
        bus.rx_strobe = 1'b0;
        reset         = 1'b0;
        @(negedge clk);
        read_row(8'd0, v);  check("keep_row0",  v, 32'h01F0_100F);
        read_row(8'd24, v); check("keep_row24", v, 32'h0000_0000);
        read_row(8'd25, v); check("keep_row25", v, 32'hFFFF_FFFF);

        // New frame after reset; last byte and next frame's first byte back to back.
        base_fd = fd_cnt; base_tx = tx_cnt; base_led = led_tog;
        for (int i = 0; i < 319; i++) send(8'hFF);
        check("f2_no_early_done", 32'(fd_cnt - base_fd),   32'd0);
        check("f2_led_319",       32'(led_tog - base_led), 32'd319);
        bus.rx_data   = 8'h00;
        bus.rx_strobe = 1'b1;
        @(negedge clk);
        bus.rx_data   = 8'h03;
        @(negedge clk);
        bus.rx_strobe = 1'b0;
        @(negedge clk);
        check("f2_frame_done_cnt", 32'(fd_cnt - base_fd),   32'd1);
        check("f2_tx_cnt",         32'(tx_cnt - base_tx),   32'd1);
        check("f2_led_321",        32'(led_tog - base_led), 32'd321);

        bus.row = 8'd79;
        @(negedge clk);
        check("row79", bus.pixels, 32'hFFF0_FFF0);
        bus.row = 8'd80;
        @(negedge clk);
        check("row80_zero", bus.pixels, 32'h0);
        read_row(8'd200, v); check("row200_zero", v, 32'h0);
        read_row(8'd0, v);   check("b2b_row0",    v, 32'h1FFF_1FFF);

        // Idle gap mid-frame.
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        base_fd = fd_cnt; base_tx = tx_cnt;
        for (int i = 0; i < 10; i++) send(8'hFF);
        repeat (20) @(negedge clk);
        send(8'h00);
`ifdef FB_LOADER_TIMEOUT_EN
        read_row(8'd0, v); check("idle_row0", v, 32'h0FFF_0FFF);
        read_row(8'd2, v); check("idle_row2", v, 32'hFFFF_FFFF);
`else
        read_row(8'd0, v); check("idle_row0", v, 32'hFFFF_FFFF);
        read_row(8'd2, v); check("idle_row2", v, 32'hFF0F_FF0F);
`endif
        check("idle_no_done", 32'(fd_cnt - base_fd), 32'd0);
        check("idle_no_tx",   32'(tx_cnt - base_tx), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
